// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs, stage enables, memory handshake and
// performance counters exchanged between the pipeline and hazard_stall_ctrl.
`default_nettype none

interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             pipe_flush;
    logic             mem_stall;
    logic             dmem_req;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Pipeline / memory side: drives hazard information, consumes enables.
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken,
               mem_mem_read, mem_mem_write, dmem_ready,
        input  pc_write, if_id_write, id_ex_bubble, pipe_flush, mem_stall,
               dmem_req, timeout_err, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken,
               mem_mem_read, mem_mem_write, dmem_ready,
        output pc_write, if_id_write, id_ex_bubble, pipe_flush, mem_stall,
               dmem_req, timeout_err, stall_cycles, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: 5-stage pipeline stall/flush control with a data-memory wait FSM.
// Optional macro HAZ_PERF_CNT_EN enables the stall/flush performance counters.
`default_nettype none

module hazard_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_acc;
    logic load_use;
    logic stall_raw;
    logic req_raw;
    logic err_raw;
    logic pc_raw;
    logic ifid_raw;
    logic bubble_raw;
    logic flush_raw;

    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic pipe_flush;
    logic mem_stall;
    logic dmem_req;
    logic timeout_err;

    assign mem_acc  = bus.mem_mem_read | bus.mem_mem_write;
    // A load writing x0 produces nothing to forward, so it never stalls.
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs1) ||
                       (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_raw  = 1'b0;
        req_raw    = 1'b0;
        err_raw    = 1'b0;
        case (state_q)
            RUN: begin
                req_raw = mem_acc;
                if (mem_acc && !bus.dmem_ready) begin
                    stall_raw  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_ONE;
                end
            end
            MEM_WAIT: begin
                req_raw   = 1'b1;
                stall_raw = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_ONE;
                end
            end
            ERR: begin
                stall_raw = 1'b1;
                err_raw   = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_raw     = 1'b1;
        ifid_raw   = 1'b1;
        bubble_raw = 1'b0;
        flush_raw  = 1'b0;
        if (stall_raw) begin
            pc_raw   = 1'b0;
            ifid_raw = 1'b0;
        end else if (bus.ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use match is moot.
            flush_raw = 1'b1;
        end else if (load_use) begin
            pc_raw     = 1'b0;
            ifid_raw   = 1'b0;
            bubble_raw = 1'b1;
        end
    end

    // Reset forces every output low immediately, independent of the clock.
    assign pc_write     = rst_n & pc_raw;
    assign if_id_write  = rst_n & ifid_raw;
    assign id_ex_bubble = rst_n & bubble_raw;
    assign pipe_flush   = rst_n & flush_raw;
    assign mem_stall    = rst_n & stall_raw;
    assign dmem_req     = rst_n & req_raw;
    assign timeout_err  = rst_n & err_raw;

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.pipe_flush   = pipe_flush;
    assign bus.mem_stall    = mem_stall;
    assign bus.dmem_req     = dmem_req;
    assign bus.timeout_err  = timeout_err;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((mem_stall || id_ex_bubble) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (pipe_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors for hazard_stall_ctrl with TIMEOUT = 4.
`default_nettype none

module tb_hazard_stall_ctrl;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    hazard_stall_ctrl_if #(.CNT_W(32)) bus ();

    hazard_stall_ctrl #(
        .TIMEOUT (4),
        .TO_W    (8),
        .CNT_W   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic idle();
        bus.id_rs1          = 5'd0;
        bus.id_rs2          = 5'd0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_rd           = 5'd0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_mem_read    = 1'b0;
        bus.mem_mem_write   = 1'b0;
        bus.dmem_ready      = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        bus.mem_mem_read    = 1'b1;
        bus.ex_branch_taken = 1'b1;
        settle();
        check("rst_pc_write", 32'(bus.pc_write), 32'd0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check("rst_pipe_flush", 32'(bus.pipe_flush), 32'd0);
        check("rst_stall_cycles", bus.stall_cycles, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        settle();
        check("idle_pc_write", 32'(bus.pc_write), 32'd1);
        check("idle_if_id_write", 32'(bus.if_id_write), 32'd1);
        check("idle_bubble", 32'(bus.id_ex_bubble), 32'd0);

        // load-use on rs1
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
        settle();
        check("lu_pc_write", 32'(bus.pc_write), 32'd0);
        check("lu_if_id_write", 32'(bus.if_id_write), 32'd0);
        check("lu_bubble", 32'(bus.id_ex_bubble), 32'd1);
        step();
        check("lu_stall_cycles", bus.stall_cycles, cnt_exp(1));

        bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
        settle();
        check("x0_bubble", 32'(bus.id_ex_bubble), 32'd0);
        check("x0_pc_write", 32'(bus.pc_write), 32'd1);
        step();

        // rs2 match only counts when the ID instruction reads rs2
        bus.ex_rd = 5'd7; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b0;
        settle();
        check("rs2_unused_bubble", 32'(bus.id_ex_bubble), 32'd0);
        step();
        bus.id_uses_rs2 = 1'b1;
        settle();
        check("rs2_used_bubble", 32'(bus.id_ex_bubble), 32'd1);
        check("rs2_used_pc_write", 32'(bus.pc_write), 32'd0);
        step();
        check("rs2_stall_cycles", bus.stall_cycles, cnt_exp(2));

        // taken branch overrides a simultaneous load-use
        bus.ex_branch_taken = 1'b1;
        settle();
        check("br_flush", 32'(bus.pipe_flush), 32'd1);
        check("br_pc_write", 32'(bus.pc_write), 32'd1);
        check("br_bubble", 32'(bus.id_ex_bubble), 32'd0);
        step();
        idle();
        settle();
        check("br_flush_count", bus.flush_count, cnt_exp(1));
        check("br_stall_unchanged", bus.stall_cycles, cnt_exp(2));

        reset_pulse();
        check("rst2_stall_cycles", bus.stall_cycles, 32'd0);
        check("rst2_flush_count", bus.flush_count, 32'd0);

        // load that waits 3 cycles, completes on the 4th
        bus.mem_mem_read = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ex_branch_taken = (i == 1);
            settle();
            check("mw_stall", 32'(bus.mem_stall), 32'd1);
            check("mw_req", 32'(bus.dmem_req), 32'd1);
            check("mw_pc_write", 32'(bus.pc_write), 32'd0);
            check("mw_flush", 32'(bus.pipe_flush), 32'd0);
            step();
        end
        bus.ex_branch_taken = 1'b0;
        bus.dmem_ready = 1'b1;
        settle();
        check("mw_done_stall", 32'(bus.mem_stall), 32'd1);
        check("mw_done_req", 32'(bus.dmem_req), 32'd1);
        step();
        bus.mem_mem_read = 1'b0;
        settle();
        check("mw_run_stall", 32'(bus.mem_stall), 32'd0);
        check("mw_run_pc_write", 32'(bus.pc_write), 32'd1);
        check("mw_stall_cycles", bus.stall_cycles, cnt_exp(4));
        check("mw_flush_count", bus.flush_count, cnt_exp(0));
        step();

        // ready access completes without stalling
        bus.mem_mem_read = 1'b1; bus.dmem_ready = 1'b1;
        settle();
        check("hit_stall", 32'(bus.mem_stall), 32'd0);
        check("hit_req", 32'(bus.dmem_req), 32'd1);
        step();

        // store that never completes: TIMEOUT wait cycles, then fault
        bus.mem_mem_read = 1'b0; bus.mem_mem_write = 1'b1; bus.dmem_ready = 1'b0;
        settle();
        check("to_first_stall", 32'(bus.mem_stall), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("to_wait_err", 32'(bus.timeout_err), 32'd0);
            check("to_wait_req", 32'(bus.dmem_req), 32'd1);
            step();
        end
        settle();
        check("to_err", 32'(bus.timeout_err), 32'd1);
        check("to_err_req", 32'(bus.dmem_req), 32'd0);
        check("to_err_stall", 32'(bus.mem_stall), 32'd1);
        step();
        bus.dmem_ready = 1'b1;
        settle();
        check("to_sticky_err", 32'(bus.timeout_err), 32'd1);
        check("to_sticky_stall", 32'(bus.mem_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("to_rst_err", 32'(bus.timeout_err), 32'd0);
        check("to_rst_stall", 32'(bus.mem_stall), 32'd0);
        check("to_rst_pc_write", 32'(bus.pc_write), 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        settle();
        check("to_after_err", 32'(bus.timeout_err), 32'd0);
        check("to_after_pc_write", 32'(bus.pc_write), 32'd1);
        step();

        // asynchronous reset in the middle of a wait
        bus.mem_mem_read = 1'b1; bus.dmem_ready = 1'b0;
        step();
        settle();
        check("mid_req", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus.dmem_req), 32'd0);
        check("mid_rst_stall", 32'(bus.mem_stall), 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        settle();
        check("mid_run_stall", 32'(bus.mem_stall), 32'd0);
        check("mid_run_pc_write", 32'(bus.pc_write), 32'd1);
        check("mid_stall_cycles", bus.stall_cycles, 32'd0);
        check("mid_flush_count", bus.flush_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It generates PC/IF-ID write enables, ID/EX bubble insertion and branch flush for the datapath. It also runs a handshake FSM that freezes the whole pipeline while a MEM-stage load or store waits on a multi-cycle data memory. It sits beside the main control decoder and consumes its MemRead/MemWrite/Branch results as they travel down the pipeline registers.

Parameters:
TIMEOUT, 255, max consecutive MEM_WAIT cycles before declaring a memory fault
TO_W, 8, width of the wait counter; must hold TIMEOUT
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 field of the instruction in ID
id_rs2  in  5  rs2 field of the instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2 (R-type, sd, beq)
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX
mem_mem_read  in  1  MEM-stage instruction is a load
mem_mem_write  in  1  MEM-stage instruction is a store
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC register write enable
if_id_write  out  1  IF/ID register write enable
id_ex_bubble  out  1  zero control fields entering ID/EX
pipe_flush  out  1  clear IF/ID and ID/EX (taken branch)
mem_stall  out  1  freeze all pipeline registers, including EX/MEM and MEM/WB
dmem_req  out  1  data memory request
timeout_err  out  1  sticky memory timeout fault
stall_cycles  out  CNT_W  saturating count of stalled cycles
flush_count  out  CNT_W  saturating count of branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- While rst_n is low, every output is 0. Asserting reset from any state, including mid-access, returns to RUN in zero cycles and drops dmem_req immediately.
- Define mem_acc = mem_mem_read | mem_mem_write.
- RUN:
  - dmem_req = mem_acc.
  - If mem_acc is 1 and dmem_ready is 1: the access completes with no stall; stay in RUN.
  - If mem_acc is 1 and dmem_ready is 0: assert mem_stall this cycle; go to MEM_WAIT and load the wait counter with 1.
- MEM_WAIT:
  - dmem_req = 1 and mem_stall = 1.
  - If dmem_ready is 1: go to RUN; mem_stall is still 1 this cycle and the pipeline advances on the next cycle.
  - Else if the wait counter equals TIMEOUT: go to ERR and set timeout_err.
  - Else: increment the wait counter.
- ERR:
  - mem_stall = 1, dmem_req = 0, timeout_err = 1.
  - Leaves ERR only via reset.
- Stage-enable priority, highest first. Only one rule applies per cycle.
  1. mem_stall = 1: pc_write = 0, if_id_write = 0, id_ex_bubble = 0, pipe_flush = 0.
  2. ex_branch_taken: pipe_flush = 1, pc_write = 1, if_id_write = 1, id_ex_bubble = 0. A load-use hazard in the same cycle is ignored because the ID instruction is squashed.
  3. Load-use: condition is ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))). Outputs: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
  4. Otherwise: pc_write = 1, if_id_write = 1, all others 0.
- Output timing:
  - All stage-enable outputs are combinational from the inputs and the current state; there is zero latency from hazard detection to enable.
  - Counters and the FSM are registered.
- stall_cycles increments by 1 in any cycle with mem_stall = 1 or load-use bubble = 1. It saturates at all-ones.
- flush_count increments by 1 in each cycle with pipe_flush = 1. It saturates at all-ones.
- A load with ex_rd = x0 never stalls.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: stall_cycles and flush_count are implemented as above.
- Undefined: both counters are removed and the outputs are tied to 0. All other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, dmem_ready = 1 -> one cycle with pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Repeat with ex_rd = 0 -> no stall.
- Store, rs2 only: ex_rd = 7, id_rs2 = 7, id_uses_rs2 = 0 -> no bubble. With id_uses_rs2 = 1 -> bubble.
- Memory wait: mem_mem_read = 1 with dmem_ready low for 3 cycles, then high -> mem_stall = 1 for 4 cycles, dmem_req = 1 throughout, FSM back in RUN, stall_cycles = 4.
- Branch vs load-use in the same cycle: ex_branch_taken = 1 plus a load-use match -> pipe_flush = 1, pc_write = 1, id_ex_bubble = 0, flush_count += 1.
- Timeout: mem_mem_write = 1 with dmem_ready held low for TIMEOUT + 2 cycles (TIMEOUT = 4) -> timeout_err rises after 4 wait cycles; dmem_req = 0 and mem_stall = 1 persist. Pulse rst_n low -> all outputs 0, FSM in RUN.
- Reset mid-access: rst_n low during MEM_WAIT -> dmem_req = 0 immediately. Counters read 0 after release.
